seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Two-digit seven-segment scan controller for the LED display path. Accepts the binary count (0–99) from the button counter, converts it to BCD with a sequential shift-add-3 engine, and time-multiplexes the shared segment bus between the two digit anodes. A blanking gap between digit slots prevents ghosting. The block sits between the counter and the board's anode and segment pins.

## Interface
- `SCAN_DIV`, 100000: clk cycles per digit slot, gap included; legal range ≥ 4.
- `BLANK_CYC`, 1000: cycles at the end of each slot with everything dark; 1 ≤ BLANK_CYC < SCAN_DIV.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `num`  in  7  binary value to display; synchronous to clk.
- `an`  out  2  digit enables, active-high; bit0 = units, bit1 = tens.
- `seg`  out  8  segments, active-high, ordered {dp,g,f,e,d,c,b,a}; dp is always 0.
- `conv_busy`  out  1  high while a BCD conversion is in progress.
- `frame_tick`  out  1  one-cycle pulse at the start of each SHOW0 slot.

## Operation
- **Conversion FSM:** states IDLE, CONV, DONE. It keeps an internal `last_num`.
  - IDLE: when `num != last_num`, capture `last_num <= num`, load the shift register, clear the 3-bit iteration count, and go to CONV.
  - CONV: run 7 iterations, one per clk. In each iteration, add 3 to any BCD nibble ≥ 5, then shift left by 1. After the 7th iteration, go to DONE.
  - DONE: write `disp_tens` and `disp_units` atomically, then return to IDLE.
- **Out of range:** if the captured value is > 99, DONE writes an error flag. Both digits then show the pattern 8'h40 ("-").
- **Input change mid-conversion:** a change of `num` during CONV is not accepted. The current conversion completes. IDLE sees the mismatch and starts a new conversion on the following edge.
- **Scan FSM:** states SHOW0 → GAP0 → SHOW1 → GAP1 → SHOW0, driven by a slot counter.
  - SHOW0 and SHOW1 each last SCAN_DIV − BLANK_CYC cycles.
  - GAP0 and GAP1 each last BLANK_CYC cycles.
- **Outputs per state:**
  - SHOW0: `an` = 2'b01, `seg` = decode(units).
  - SHOW1: `an` = 2'b10, `seg` = decode(tens).
  - GAP0 and GAP1: `an` = 2'b00, `seg` = 8'h00.
- **Decode table, digits 0–9 ({g..a} hex):** 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
- **Display source:** scan reads only the display registers, never the shift register. A partially converted value is never visible.
- **`conv_busy`:** high in CONV and DONE, low in IDLE.

## Timing
- **Reset values:**
  - `an` = 0, `seg` = 0, `conv_busy` = 0, `frame_tick` = 0.
  - Display registers = 0, error flag = 0, `last_num` = 0.
  - Scan state = SHOW0 with slot counter 0; conversion state = IDLE.
- **Registered outputs:** `an`, `seg` and `frame_tick` reflect the scan state one clk after state entry. The first SHOW0 after reset release therefore drives `an` = 01 on the first edge.
- **Conversion latency:** mismatch detected at edge E; CONV occupies edges E+1 to E+7; display registers update at edge E+8. The new value appears at the start of the next SHOW slot after E+8.
- **Slot changes:** display registers that update mid-slot are reflected from the next edge, since `seg` is registered from the current registers. No glitch occurs within a GAP.
- **Reset mid-operation:** an asserted `rst_n` aborts any conversion or slot immediately and returns everything to the reset values.
- **Wrap:** a `num` change from 99 to 0 is an ordinary conversion, and the new value is shown 8 clks later.

## Configuration
- `SEG_LZB_EN` (leading-zero blanking):
  - **Defined:** when `disp_tens` = 0 and the error flag = 0, SHOW1 drives `an` = 2'b00 and `seg` = 8'h00. The tens digit is dark, but slot timing is unchanged.
  - **Undefined:** the tens digit always shows its decoded value, e.g. "07".

## Test plan
- SCAN_DIV=10, BLANK_CYC=2, `num`=0 held, release reset → `an` sequence 01×8, 00×2, 10×8, 00×2, repeating; `frame_tick` every 20 clks; units `seg`=3F; tens 3F without the macro, dark with it.
- `num` 0→57 at edge E → `conv_busy` high E+1 to E+8; display registers = 5/7 at E+8; SHOW0 `seg`=6D; SHOW1 `seg`=07.
- `num` 12→34 at E+3 of a conversion → first conversion ends at E+8; second starts at E+9 and finishes at E+17 showing 3/4; 12 is visible in between.
- `num`=100, then 127 → both slots show `seg`=40; `num`=99 afterwards → 6F/6F.
- `num`=9 with `SEG_LZB_EN` → SHOW1 `an`=00 `seg`=00, SHOW0 `seg`=6F; `num`=10 → tens `seg`=06 with `an`=10.
- Assert `rst_n` low mid-CONV and mid-SHOW1 → all outputs 0 within the same cycle; after release, display shows 0 and a pending `num`≠0 reconverts.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Two-digit seven-segment scan controller: sequential binary-to-BCD conversion plus anode/segment multiplexing.
// Optional leading-zero blanking of the tens digit is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] num,
  output logic [1:0] an,
  output logic [7:0] seg,
  output logic       conv_busy,
  output logic       frame_tick
);

  // state | meaning
  // C_IDLE  | waiting for num to differ from last_num
  // C_CONV  | seven shift-add-3 iterations
  // C_DONE  | commit BCD result and error flag to the display registers
  // S_SHOW0 | units digit lit
  // S_GAP0  | all dark between units and tens
  // S_SHOW1 | tens digit lit
  // S_GAP1  | all dark between tens and units
  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_CONV = 2'd1;
  localparam logic [1:0] C_DONE = 2'd2;

  localparam logic [1:0] S_SHOW0 = 2'd0;
  localparam logic [1:0] S_GAP0  = 2'd1;
  localparam logic [1:0] S_SHOW1 = 2'd2;
  localparam logic [1:0] S_GAP1  = 2'd3;

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
  localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - BLANK_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYC - 1);

  localparam logic [7:0] SEG_DASH = 8'h40;

  logic [1:0]    conv_state;
  logic [6:0]    last_num;
  logic [14:0]   shift_q;
  logic [2:0]    iter_q;
  logic [3:0]    disp_tens;
  logic [3:0]    disp_units;
  logic          err_q;

  logic [1:0]    scan_state;
  logic [CW-1:0] slot_cnt;
  logic [CW-1:0] slot_last;

  logic [1:0]    an_d;
  logic [7:0]    seg_d;
  logic          frame_tick_d;

  function automatic logic [14:0] dabble_step(input logic [14:0] s);
    logic [14:0] t;
    t = s;
    if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
    if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

  function automatic logic [7:0] decode(input logic [3:0] d);
    logic [7:0] r;
    case (d)
      4'd0:    r = 8'h3F;
      4'd1:    r = 8'h06;
      4'd2:    r = 8'h5B;
      4'd3:    r = 8'h4F;
      4'd4:    r = 8'h66;
      4'd5:    r = 8'h6D;
      4'd6:    r = 8'h7D;
      4'd7:    r = 8'h07;
      4'd8:    r = 8'h7F;
      4'd9:    r = 8'h6F;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Conversion engine: a change of num is only looked at in IDLE, so a mid-conversion
  // change is picked up on the edge after DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_state <= C_IDLE;
      last_num   <= 7'd0;
      shift_q    <= 15'd0;
      iter_q     <= 3'd0;
      disp_tens  <= 4'd0;
      disp_units <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      case (conv_state)
        C_IDLE: begin
          if (num != last_num) begin
            last_num   <= num;
            shift_q    <= {8'd0, num};
            iter_q     <= 3'd0;
            conv_state <= C_CONV;
          end
        end
        C_CONV: begin
          shift_q <= dabble_step(shift_q);
          iter_q  <= iter_q + 3'd1;
          if (iter_q == 3'd6) conv_state <= C_DONE;
        end
        C_DONE: begin
          disp_tens  <= shift_q[14:11];
          disp_units <= shift_q[10:7];
          err_q      <= (last_num > 7'd99);
          conv_state <= C_IDLE;
        end
        default: conv_state <= C_IDLE;
      endcase
    end
  end

  assign conv_busy = (conv_state != C_IDLE);

  assign slot_last = (scan_state == S_SHOW0 || scan_state == S_SHOW1) ? SHOW_LAST : GAP_LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_state <= S_SHOW0;
      slot_cnt   <= '0;
    end else if (slot_cnt == slot_last) begin
      slot_cnt <= '0;
      case (scan_state)
        S_SHOW0: scan_state <= S_GAP0;
        S_GAP0:  scan_state <= S_SHOW1;
        S_SHOW1: scan_state <= S_GAP1;
        default: scan_state <= S_SHOW0;
      endcase
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Segments come only from the committed display registers, never from shift_q.
  always_comb begin
    an_d         = 2'b00;
    seg_d        = 8'h00;
    frame_tick_d = (scan_state == S_SHOW0) && (slot_cnt == '0);
    case (scan_state)
      S_SHOW0: begin
        an_d  = 2'b01;
        seg_d = err_q ? SEG_DASH : decode(disp_units);
      end
      S_SHOW1: begin
        an_d  = 2'b10;
        seg_d = err_q ? SEG_DASH : decode(disp_tens);
`ifdef SEG_LZB_EN
        if (!err_q && disp_tens == 4'd0) begin
          an_d  = 2'b00;
          seg_d = 8'h00;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 2'b00;
      seg        <= 8'h00;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      frame_tick <= frame_tick_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with SCAN_DIV=10, BLANK_CYC=2 (20-clk frame).
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] num;
  logic [1:0] an;
  logic [7:0] seg;
  logic       conv_busy;
  logic       frame_tick;

  int errors;
  int checks;
  int pos;

`ifdef SEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic [7:0] dec_tab [10];

  seg_scan_ctrl #(.SCAN_DIV(10), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .num(num), .an(an), .seg(seg),
    .conv_busy(conv_busy), .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    pos = (pos + 1) % 20;
  endtask

  // Expected outputs after the edge at frame position p (0 = first edge of SHOW0).
  function automatic logic [1:0] exp_an(input int p, input int tens, input bit err);
    if (p < 8) return 2'b01;
    if (p >= 10 && p < 18) return (LZB && tens == 0 && !err) ? 2'b00 : 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [7:0] exp_seg(input int p, input int units, input int tens, input bit err);
    if (p < 8) return err ? 8'h40 : dec_tab[units];
    if (p >= 10 && p < 18) begin
      if (err) return 8'h40;
      if (LZB && tens == 0) return 8'h00;
      return dec_tab[tens];
    end
    return 8'h00;
  endfunction

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pos   = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    num   = 7'd0;
    #2;
    checks++;
    if (an !== 2'b00 || seg !== 8'h00 || conv_busy !== 1'b0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals an=%b seg=%h busy=%b ft=%b required all 0", an, seg, conv_busy, frame_tick);
    end
    release_reset();
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (an !== exp_an(pos, 0, 0) || seg !== exp_seg(pos, 0, 0, 0) ||
          frame_tick !== (pos == 0) || conv_busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_scan pos=%0d an=%b req %b seg=%h req %h ft=%b busy=%b",
                 pos, an, exp_an(pos, 0, 0), seg, exp_seg(pos, 0, 0, 0), frame_tick, conv_busy);
      end
    end
  endtask

  task automatic test_convert();
    num = 7'd57;
    for (int k = 0; k <= 8; k++) begin
      tick();
      checks++;
      if (conv_busy !== (k < 8)) begin
        errors++;
        $display("FAIL conv57_busy k=%0d busy=%b req %b", k, conv_busy, (k < 8));
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (an !== exp_an(pos, 5, 0) || seg !== exp_seg(pos, 7, 5, 0)) begin
        errors++;
        $display("FAIL show57 pos=%0d an=%b req %b seg=%h req %h",
                 pos, an, exp_an(pos, 5, 0), seg, exp_seg(pos, 7, 5, 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ea;
    logic [7:0] es;
    num = 7'd12;
    for (int k = 0; k <= 17; k++) begin
      if (k == 3) num = 7'd34;
      tick();
      ea = (k <= 8) ? exp_an(pos, 5, 0) : exp_an(pos, 1, 0);
      es = (k <= 8) ? exp_seg(pos, 7, 5, 0) : exp_seg(pos, 2, 1, 0);
      checks++;
      if (an !== ea || seg !== es) begin
        errors++;
        $display("FAIL b2b_disp k=%0d pos=%0d an=%b req %b seg=%h req %h", k, pos, an, ea, seg, es);
      end
      if (k == 8 || k == 9 || k == 17) begin
        checks++;
        if (conv_busy !== (k == 9)) begin
          errors++;
          $display("FAIL b2b_busy k=%0d busy=%b req %b", k, conv_busy, (k == 9));
        end
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (an !== exp_an(pos, 3, 0) || seg !== exp_seg(pos, 4, 3, 0)) begin
        errors++;
        $display("FAIL show34 pos=%0d an=%b req %b seg=%h req %h",
                 pos, an, exp_an(pos, 3, 0), seg, exp_seg(pos, 4, 3, 0));
      end
    end
  endtask

  task automatic test_out_of_range();
    int vals [3];
    bit errs [3];
    vals = '{100, 127, 99};
    errs = '{1'b1, 1'b1, 1'b0};
    for (int v = 0; v < 3; v++) begin
      num = 7'(vals[v]);
      for (int k = 0; k <= 8; k++) tick();
      checks++;
      if (conv_busy !== 1'b0) begin
        errors++;
        $display("FAIL oor_busy val=%0d busy=%b req 0", vals[v], conv_busy);
      end
      for (int i = 0; i < 20; i++) begin
        tick();
        checks++;
        if (an !== exp_an(pos, 9, errs[v]) || seg !== exp_seg(pos, 9, 9, errs[v])) begin
          errors++;
          $display("FAIL oor_disp val=%0d pos=%0d an=%b req %b seg=%h req %h", vals[v], pos,
                   an, exp_an(pos, 9, errs[v]), seg, exp_seg(pos, 9, 9, errs[v]));
        end
      end
    end
  endtask

  task automatic test_wrap();
    num = 7'd0;
    for (int k = 0; k <= 8; k++) begin
      tick();
      checks++;
      if (conv_busy !== (k < 8)) begin
        errors++;
        $display("FAIL wrap_busy k=%0d busy=%b req %b", k, conv_busy, (k < 8));
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (an !== exp_an(pos, 0, 0) || seg !== exp_seg(pos, 0, 0, 0)) begin
        errors++;
        $display("FAIL wrap_disp pos=%0d an=%b req %b seg=%h req %h",
                 pos, an, exp_an(pos, 0, 0), seg, exp_seg(pos, 0, 0, 0));
      end
    end
  endtask

  task automatic test_lzb();
    int vals [2];
    vals = '{9, 10};
    for (int v = 0; v < 2; v++) begin
      num = 7'(vals[v]);
      for (int k = 0; k <= 8; k++) tick();
      for (int i = 0; i < 20; i++) begin
        tick();
        checks++;
        if (an !== exp_an(pos, vals[v] / 10, 0) || seg !== exp_seg(pos, vals[v] % 10, vals[v] / 10, 0)) begin
          errors++;
          $display("FAIL lzb_disp val=%0d pos=%0d an=%b req %b seg=%h req %h", vals[v], pos, an,
                   exp_an(pos, vals[v] / 10, 0), seg, exp_seg(pos, vals[v] % 10, vals[v] / 10, 0));
        end
      end
    end
  endtask

  task automatic test_reset_mid_conv();
    num = 7'd57;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 2'b00 || seg !== 8'h00 || conv_busy !== 1'b0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_conv an=%b seg=%h busy=%b ft=%b required all 0", an, seg, conv_busy, frame_tick);
    end
    release_reset();
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (an !== exp_an(pos, (k <= 8) ? 0 : 5, 0) || seg !== exp_seg(pos, (k <= 8) ? 0 : 7, (k <= 8) ? 0 : 5, 0) ||
          frame_tick !== (pos == 0) || conv_busy !== (k < 8)) begin
        errors++;
        $display("FAIL rst_reconv k=%0d an=%b seg=%h ft=%b busy=%b", k, an, seg, frame_tick, conv_busy);
      end
    end
  endtask

  task automatic test_reset_mid_show1();
    for (int i = 0; i < 20 && pos != 12; i++) tick();
    checks++;
    if (an !== exp_an(12, 5, 0)) begin
      errors++;
      $display("FAIL pre_rst_show1 an=%b req %b", an, exp_an(12, 5, 0));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 2'b00 || seg !== 8'h00 || conv_busy !== 1'b0 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_show1 an=%b seg=%h busy=%b ft=%b required all 0", an, seg, conv_busy, frame_tick);
    end
    release_reset();
    tick();
    checks++;
    if (an !== 2'b01 || seg !== 8'h3F || frame_tick !== 1'b1 || conv_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_show1_restart an=%b req 01 seg=%h req 3f ft=%b req 1 busy=%b req 1",
               an, seg, frame_tick, conv_busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    pos    = 0;
    dec_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    test_reset();
    test_convert();
    test_back_to_back();
    test_out_of_range();
    test_wrap();
    test_lzb();
    test_reset_mid_conv();
    test_reset_mid_show1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
